// File: rtl/fb_pkg.sv
// Shared types and constants for the scanline prefetcher.
// Pixel formats, fetch FSM states and the default line geometry.
package fb_pkg;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_LINE_STRIDE = 1280;
    localparam int DEF_ADDR_W      = 27;
    localparam int WPL             = DEF_H_ACTIVE / 8;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        DRAIN
    } fetch_state_e;

    function automatic rgb888_t rgb565_to_rgb888(input rgb565_t p);
        rgb888_t c;
        c.r = {p.r, p.r[4:2]};
        c.g = {p.g, p.g[5:4]};
        c.b = {p.b, p.b[4:2]};
        return c;
    endfunction

endpackage

// File: rtl/line_buffer_pp.sv
// Ping-pong line buffer: two banks of WORDS x DW, one write port,
// one registered read port, no reset so it maps onto block RAM.
module line_buffer_pp
    import fb_pkg::*;
#(
    parameter int WORDS = WPL,
    parameter int DW    = 128,
    parameter int WAW   = $clog2(WORDS)
) (
    input  logic           clk,
    input  logic           i_we,
    input  logic           i_wr_bank,
    input  logic [WAW-1:0] i_wr_word,
    input  logic [DW-1:0]  i_wr_data,
    input  logic           i_rd_bank,
    input  logic [WAW-1:0] i_rd_word,
    output logic [DW-1:0]  o_rd_data
);

    logic [DW-1:0] r_mem [2*WORDS];
    logic [DW-1:0] r_rd_data;
    logic [WAW:0]  w_wr_idx;
    logic [WAW:0]  w_rd_idx;

    assign w_wr_idx = i_wr_bank ? (WAW+1)'(WORDS) + {1'b0, i_wr_word}
                                : {1'b0, i_wr_word};
    assign w_rd_idx = i_rd_bank ? (WAW+1)'(WORDS) + {1'b0, i_rd_word}
                                : {1'b0, i_rd_word};

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
        r_rd_data <= r_mem[w_rd_idx];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/scanline_prefetcher.sv
// Fetches the next visible scanline from DDR into a ping-pong buffer
// while the display reads the other bank and expands RGB565 to RGB888.
module scanline_prefetcher
    import fb_pkg::*;
#(
    parameter int                H_ACTIVE    = DEF_H_ACTIVE,
    parameter int                V_ACTIVE    = DEF_V_ACTIVE,
    parameter int                V_TOTAL     = DEF_V_TOTAL,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] FB_BASE     = '0,
    parameter int                LINE_STRIDE = DEF_LINE_STRIDE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [9:0]        line_index,
    input  logic [9:0]        pix_x,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_rvalid,
    output logic              underrun,
    output logic              busy
);

    localparam int NW  = H_ACTIVE / 8;
    localparam int WAW = $clog2(NW);

    fetch_state_e      r_state;
    fetch_state_e      w_nstate;
    logic [WAW-1:0]    r_w;
    logic [ADDR_W-1:0] r_addr;
    logic [9:0]        r_tgt;
    logic              r_tgt_ok;
    logic [1:0]        r_valid;
    logic              r_disp_sel;
    logic              r_disp_en;
    logic              r_underrun;
    logic              r_black;
    logic [2:0]        r_lane;

    logic [10:0]       w_next_line;
    logic              w_wrap;
    logic              w_has_tgt;
    logic [9:0]        w_tgt;
    logic              w_last;
    logic              w_pend;
    logic              w_we;
    logic              w_load;
    logic [9:0]        w_load_t;
    logic              w_swap;
    logic              w_fetch_bank;
    logic [WAW-1:0]    w_rd_word;
    logic [127:0]      w_rd_data;
    logic [15:0]       w_px;
    rgb888_t           w_rgb;

    function automatic logic [ADDR_W-1:0] line_base(input logic [9:0] t);
        return FB_BASE + ADDR_W'(t) * ADDR_W'(LINE_STRIDE);
    endfunction

    assign w_next_line  = {1'b0, line_index} + 11'd1;
    assign w_wrap       = line_index == 10'(V_TOTAL - 1);
    assign w_has_tgt    = w_wrap || (w_next_line < 11'(V_ACTIVE));
    assign w_tgt        = w_wrap ? '0 : w_next_line[9:0];
    assign w_last       = r_w == WAW'(NW - 1);
    assign w_fetch_bank = ~r_disp_sel;
    assign w_swap       = (line_index < 10'(V_ACTIVE)) && r_valid[w_fetch_bank];

    // A request is still in flight if it was accepted but its data not seen.
    assign w_pend = (r_state == ISSUE) ? (mem_ack & ~mem_rvalid)
                                       : ~mem_rvalid;

    always_comb begin
        w_nstate = r_state;
        w_we     = 1'b0;
        w_load   = 1'b0;
        w_load_t = w_tgt;
        if (line_start) begin
            unique case (r_state)
                ISSUE, WAIT_DATA, DRAIN: begin
                    if (w_pend) begin
                        w_nstate = DRAIN;
                    end else if (w_has_tgt) begin
                        w_nstate = ISSUE;
                        w_load   = 1'b1;
                    end else begin
                        w_nstate = IDLE;
                    end
                end
                default: begin
                    if (w_has_tgt) begin
                        w_nstate = ISSUE;
                        w_load   = 1'b1;
                    end
                end
            endcase
        end else begin
            unique case (r_state)
                ISSUE: begin
                    if (mem_ack && mem_rvalid) begin
                        w_we     = 1'b1;
                        w_nstate = w_last ? IDLE : ISSUE;
                    end else if (mem_ack) begin
                        w_nstate = WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (mem_rvalid) begin
                        w_we     = 1'b1;
                        w_nstate = w_last ? IDLE : ISSUE;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid) begin
                        w_nstate = r_tgt_ok ? ISSUE : IDLE;
                        w_load   = r_tgt_ok;
                        w_load_t = r_tgt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_w        <= '0;
            r_addr     <= '0;
            r_tgt      <= '0;
            r_tgt_ok   <= 1'b0;
            r_valid    <= '0;
            r_disp_sel <= 1'b0;
            r_disp_en  <= 1'b0;
            r_underrun <= 1'b0;
            r_black    <= 1'b1;
            r_lane     <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_load) begin
                r_w    <= '0;
                r_addr <= line_base(w_load_t);
            end else if (w_we) begin
                r_w    <= w_last ? '0 : r_w + 1'b1;
                r_addr <= r_addr + ADDR_W'(16);
            end
            if (w_we && w_last) begin
                r_valid[w_fetch_bank] <= 1'b1;
            end
            if (line_start) begin
                r_tgt     <= w_tgt;
                r_tgt_ok  <= w_has_tgt;
                r_disp_en <= w_swap;
                if (r_state != IDLE) begin
                    r_underrun <= 1'b1;
                end
                // The bank that becomes the fetch target is always invalidated.
                if (w_swap) begin
                    r_disp_sel          <= ~r_disp_sel;
                    r_valid[r_disp_sel] <= 1'b0;
                end else begin
                    r_valid[w_fetch_bank] <= 1'b0;
                end
            end
            r_lane  <= pix_x[2:0];
            r_black <= (pix_x >= 10'(H_ACTIVE)) || !r_disp_en
                       || !r_valid[r_disp_sel];
        end
    end

    assign w_rd_word = (pix_x < 10'(H_ACTIVE)) ? WAW'(pix_x[9:3]) : '0;

    line_buffer_pp #(
        .WORDS(NW),
        .DW   (128),
        .WAW  (WAW)
    ) u_buf (
        .clk      (clk),
        .i_we     (w_we),
        .i_wr_bank(w_fetch_bank),
        .i_wr_word(r_w),
        .i_wr_data(mem_rdata),
        .i_rd_bank(r_disp_sel),
        .i_rd_word(w_rd_word),
        .o_rd_data(w_rd_data)
    );

    assign w_px  = w_rd_data[{r_lane, 4'd0} +: 16];
    assign w_rgb = rgb565_to_rgb888(rgb565_t'(w_px));

    assign red      = r_black ? 8'd0 : w_rgb.r;
    assign green    = r_black ? 8'd0 : w_rgb.g;
    assign blue     = r_black ? 8'd0 : w_rgb.b;
    assign mem_req  = r_state == ISSUE;
    assign mem_addr = r_addr;
    assign underrun = r_underrun;
    assign busy     = r_state != IDLE;

endmodule

// File: tb/tb_scanline_prefetcher.sv
// Directed bench for scanline_prefetcher with a scripted DDR responder
// and an address-derived pixel pattern model.
module tb_scanline_prefetcher;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         line_start = 1'b0;
    logic [9:0]   line_index = '0;
    logic [9:0]   pix_x = '0;
    logic [7:0]   red, green, blue;
    logic         mem_req;
    logic [26:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         mem_rvalid = 1'b0;
    logic         underrun, busy;

    scanline_prefetcher dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .line_start(line_start),
        .line_index(line_index),
        .pix_x     (pix_x),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .underrun  (underrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int          st = 0;
    int          cnt = 0;
    int          data_dly = 5;
    int          proto_err = 0;
    bit          resp_en = 1'b1;
    bit          same_mode = 1'b0;
    logic [26:0] a_cap = '0;
    logic [26:0] alog[$];

    typedef struct {
        int          x;
        logic [23:0] rgb;
        string       name;
    } vec_t;

    vec_t vt[5];

    function automatic logic [15:0] pix_of(input logic [26:0] a, input int k);
        logic [15:0] lo;
        lo = a[15:0];
        if (a < 27'd1280) return 16'hF800;
        return (lo ^ 16'h3C5A) + 16'(k * 16'h0111);
    endfunction

    function automatic logic [127:0] word_of(input logic [26:0] a);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = pix_of(a, k);
        return w;
    endfunction

    function automatic logic [23:0] exp_rgb(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)),
                8'((b << 3) | (b >> 2))};
    endfunction

    function automatic logic [23:0] model(input int line, input int x);
        logic [26:0] a;
        a = 27'(line * 1280 + (x / 8) * 16);
        return exp_rgb(pix_of(a, x % 8));
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int l);
        line_index = 10'(l);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic px(input int x, input logic [23:0] e, input string nm);
        pix_x = 10'(x);
        tick();
        check(nm, {red, green, blue}, e);
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int n;
        n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        check(nm, busy, 0);
    endtask

    // DDR responder: fixed ack/data delays, or ack+data together.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                mem_ack = 1'b0;
                mem_rvalid = 1'b0;
                case (st)
                    0: if (mem_req) begin
                        a_cap = mem_addr;
                        alog.push_back(mem_addr);
                        cnt = 0;
                        st = same_mode ? 3 : 1;
                    end
                    1: begin
                        if (!mem_req || mem_addr !== a_cap) proto_err++;
                        cnt++;
                        if (cnt >= 3) begin
                            mem_ack = 1'b1;
                            cnt = 0;
                            st = 2;
                        end
                    end
                    2: begin
                        if (mem_req) proto_err++;
                        cnt++;
                        if (cnt >= data_dly) begin
                            mem_rvalid = 1'b1;
                            mem_rdata = word_of(a_cap);
                            st = 0;
                        end
                    end
                    default: begin
                        mem_ack = 1'b1;
                        mem_rvalid = 1'b1;
                        mem_rdata = word_of(a_cap);
                        st = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int errs;
        logic [26:0] first;

        vt[0] = '{5,    24'hFF0000, "l0_x5"};
        vt[1] = '{0,    24'hFF0000, "l0_x0"};
        vt[2] = '{639,  24'hFF0000, "l0_x639"};
        vt[3] = '{640,  24'h000000, "l0_x640"};
        vt[4] = '{1023, 24'h000000, "l0_x1023"};

        repeat (3) tick();
        check("rst_rgb", {red, green, blue}, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_underrun", underrun, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick();

        alog.delete();
        pulse(524);
        check("l524_busy", busy, 1);
        wait_idle(2000, "fetch0_done");
        check("f0_count", alog.size(), 80);
        errs = 0;
        foreach (alog[i]) if (alog[i] !== 27'(i * 16)) errs++;
        check("f0_addrs", errs, 0);

        alog.delete();
        pulse(0);
        for (int i = 0; i < 5; i++) px(vt[i].x, vt[i].rgb, vt[i].name);
        wait_idle(2000, "fetch1_done");
        check("f1_count", alog.size(), 80);
        first = (alog.size() > 0) ? alog[0] : '1;
        check("f1_first", first, 27'd1280);

        alog.delete();
        pulse(479);
        repeat (3) tick();
        check("l479_busy", busy, 0);
        check("l479_nreq", alog.size(), 0);
        px(9, model(1, 9), "l479_px9");
        pulse(500);
        repeat (3) tick();
        check("l500_busy", busy, 0);
        check("l500_nreq", alog.size(), 0);
        px(5, 24'h0, "l500_black");

        same_mode = 1'b1;
        alog.delete();
        pulse(10);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
        end
        same_mode = 1'b0;
        check("same_cycles", n, 160);
        check("same_count", alog.size(), 80);
        pulse(11);
        errs = 0;
        for (int x = 0; x < 640; x++) begin
            pix_x = 10'(x);
            tick();
            if ({red, green, blue} !== model(11, x)) errs++;
        end
        check("l11_pixels", errs, 0);
        wait_idle(2000, "fetch12_done");

        data_dly = 3000;
        pulse(20);
        n = 0;
        while (st != 2 && n < 100) begin
            tick();
            n++;
        end
        check("stall_acked", st, 2);
        alog.delete();
        pulse(30);
        check("ovr_underrun", underrun, 1);
        check("ovr_busy", busy, 1);
        px(5, 24'h0, "ovr_black");
        n = 0;
        while (alog.size() == 0 && n < 4000) begin
            tick();
            n++;
        end
        data_dly = 5;
        first = (alog.size() > 0) ? alog[0] : '1;
        check("restart_addr", first, 27'(31 * 1280));
        wait_idle(2000, "fetch31_done");
        check("f31_count", alog.size(), 80);
        pulse(31);
        px(13, model(31, 13), "l31_px13");
        check("underrun_sticky", underrun, 1);
        wait_idle(2000, "fetch32_done");

        alog.delete();
        pulse(40);
        pix_x = 10'd5;
        n = 0;
        while (!(alog.size() == 41 && st == 2) && n < 2000) begin
            tick();
            n++;
        end
        check("w40_reached", alog.size(), 41);
        check("pre_rst_rgb", {red, green, blue}, model(32, 5));
        resp_en = 1'b0;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("ar_rgb", {red, green, blue}, 0);
        check("ar_req", mem_req, 0);
        check("ar_addr", mem_addr, 0);
        check("ar_underrun", underrun, 0);
        check("ar_busy", busy, 0);
        st = 0;
        cnt = 0;
        #3;
        reset_n = 1'b1;
        tick();
        mem_rdata = '1;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        tick();
        check("stray_req", mem_req, 0);
        check("stray_busy", busy, 0);
        check("stray_rgb", {red, green, blue}, 0);
        check("proto_errs", proto_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
